// File: rtl/sub_serial_pkg.sv
// Shared definitions for the serial arithmetic library: FSM state encoding and
// the one-bit full-subtractor equation used by the serial cells.
package serial_arith_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SUB  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Returns {borrow_next, difference} for a - b - bin.
  function automatic logic [1:0] fs_bit(input logic a, input logic b, input logic bin);
    logic d;
    logic bout;
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
    return {bout, d};
  endfunction

endpackage

// File: rtl/sub_serial_if.sv
// Operand/result bundle of the bit-serial subtractor. Defining SUB_SERIAL_OVF_EN
// adds the signed-overflow flag.
interface sub_serial_if #(parameter int WIDTH = 8);
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             borrow_out;
  logic             busy;
  logic             done;
`ifdef SUB_SERIAL_OVF_EN
  logic             ovf;
`endif

  modport master (
    output en, a, b,
`ifdef SUB_SERIAL_OVF_EN
    input  ovf,
`endif
    input  out, borrow_out, busy, done
  );

  modport slave (
    input  en, a, b,
`ifdef SUB_SERIAL_OVF_EN
    output ovf,
`endif
    output out, borrow_out, busy, done
  );
endinterface

// File: rtl/sub_serial_fs_cell.sv
// Combinational one-bit full subtractor: d = a - b - bin, bout = borrow out.
module serial_fs_cell
  import serial_arith_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign {bout, d} = fs_bit(a, b, bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor: a - b computed LSB first through one full-subtractor
// cell and a borrow flop. Optional SUB_SERIAL_OVF_EN adds a signed overflow flag.
module sub_serial
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  sub_serial_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] out_reg;
  logic [CW-1:0]    count;
  logic             borrow;
  logic             d_bit;
  logic             borrow_nxt;
  logic             last_bit;

  serial_fs_cell u_cell (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .bin  (borrow),
    .d    (d_bit),
    .bout (borrow_nxt)
  );

  assign last_bit = (count == CW'(WIDTH - 1));

  // Difference bits enter at the MSB and walk down, so after WIDTH shifts
  // the LSB computed first sits at bit 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      out_reg <= '0;
      count   <= '0;
      borrow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en) begin
            a_reg   <= bus.a;
            b_reg   <= bus.b;
            borrow  <= 1'b0;
            count   <= '0;
            out_reg <= '0;
            state   <= SUB;
          end
        end
        SUB: begin
          out_reg <= {d_bit, out_reg[WIDTH-1:1]};
          borrow  <= borrow_nxt;
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          count   <= count + CW'(1);
          if (last_bit) state <= DONE;
        end
        DONE: begin
          if (bus.en) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out        = out_reg;
  assign bus.borrow_out = borrow;
  assign bus.busy       = (state == SUB);
  assign bus.done       = (state == DONE);

`ifdef SUB_SERIAL_OVF_EN
  logic ovf_reg;

  // Signed overflow: borrow into the MSB differs from borrow out of the MSB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_reg <= 1'b0;
    end else if (state == IDLE && bus.en) begin
      ovf_reg <= 1'b0;
    end else if (state == SUB && last_bit) begin
      ovf_reg <= borrow ^ borrow_nxt;
    end
  end

  assign bus.ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial (WIDTH = 8), table-driven with a result scoreboard.
module tb_sub_serial;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_out;
    logic         exp_borrow;
  } vec_t;

  typedef struct {
    logic [W-1:0] out;
    logic         borrow;
    logic         ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t sb[$];

  sub_serial_if #(.WIDTH(W)) bus ();

  sub_serial #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Independent reference: plain subtraction plus sign-rule overflow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.out    = a - b;
    e.borrow = (a < b);
    e.ovf    = (a[W-1] != b[W-1]) && (e.out[W-1] != a[W-1]);
    return e;
  endfunction

  // Start an operation, wait for done, compare against the scoreboard, release.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input bit noisy, input bit check_lat, input string nm);
    int   cyc;
    int   busy_n;
    exp_t e;
    logic [W-1:0] held;
    sb.push_back(model(ta, tb_));
    @(negedge clk);
    bus.en = 1'b1;
    bus.a  = ta;
    bus.b  = tb_;
    @(negedge clk);
    bus.en = 1'b0;
    cyc    = 1;
    busy_n = 0;
    while (!bus.done && cyc < 40) begin
      if (bus.busy) busy_n++;
      if (noisy && cyc >= 2 && cyc <= 6) begin
        bus.en = 1'b1;
        bus.a  = W'($urandom);
        bus.b  = W'($urandom);
      end else begin
        bus.en = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.en = 1'b0;
    chk({nm, "_done_seen"}, {31'd0, bus.done}, 32'd1);
    if (check_lat) begin
      chk({nm, "_latency"}, cyc, 32'd9);
      chk({nm, "_busy_cycles"}, busy_n, 32'd8);
    end
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({nm, "_out"}, {24'd0, bus.out}, {24'd0, e.out});
      chk({nm, "_borrow"}, {31'd0, bus.borrow_out}, {31'd0, e.borrow});
`ifdef SUB_SERIAL_OVF_EN
      chk({nm, "_ovf"}, {31'd0, bus.ovf}, {31'd0, e.ovf});
`endif
    end
    held   = bus.out;
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    chk({nm, "_idle_done"}, {30'd0, bus.done, bus.busy}, 32'd0);
    chk({nm, "_held"}, {24'd0, bus.out}, {24'd0, held});
  endtask

  vec_t vecs[8];

  initial begin
    total  = 0;
    bad    = 0;
    bus.en = 1'b0;
    bus.a  = '0;
    bus.b  = '0;
    rst    = 1'b0;

    vecs[0] = '{8'h35, 8'h12, 8'h23, 1'b0};
    vecs[1] = '{8'h12, 8'h35, 8'hDD, 1'b1};
    vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[3] = '{8'hAA, 8'hAA, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
    vecs[5] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    vecs[6] = '{8'h80, 8'h01, 8'h7F, 1'b0};
    vecs[7] = '{8'h05, 8'h03, 8'h02, 1'b0};

    // Reset held, then idle with en low.
    repeat (2) @(negedge clk);
    chk("rst_state", {22'd0, bus.out, bus.done, bus.busy}, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_state", {22'd0, bus.out, bus.done, bus.busy}, 32'd0);
    end

    // Table vectors: constant expectations must agree with the model, then the DUT.
    for (int i = 0; i < 8; i++) begin
      exp_t m;
      m = model(vecs[i].a, vecs[i].b);
      chk($sformatf("tbl%0d_const", i), {23'd0, m.out, m.borrow},
          {23'd0, vecs[i].exp_out, vecs[i].exp_borrow});
      run_op(vecs[i].a, vecs[i].b, 1'b0, (i == 0), $sformatf("tbl%0d", i));
    end

`ifdef SUB_SERIAL_OVF_EN
    begin
      exp_t m1;
      exp_t m2;
      m1 = model(8'h80, 8'h01);
      m2 = model(8'h05, 8'h03);
      chk("ovf_model_80_01", {31'd0, m1.ovf}, 32'd1);
      chk("ovf_model_05_03", {31'd0, m2.ovf}, 32'd0);
    end
`endif

    // en and operand changes during SUB must not restart the operation.
    run_op(8'hAA, 8'h55, 1'b1, 1'b0, "noisy");
    chk("noisy_held_55", {24'd0, bus.out}, 32'h55);

    // Reset in the 4th SUB cycle aborts immediately.
    @(negedge clk);
    bus.en = 1'b1;
    bus.a  = 8'h35;
    bus.b  = 8'h12;
    @(negedge clk);
    bus.en = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_out", {24'd0, bus.out}, 32'd0);
    chk("abort_flags", {30'd0, bus.done, bus.busy}, 32'd0);
    chk("abort_borrow", {31'd0, bus.borrow_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op(8'h12, 8'h35, 1'b0, 1'b1, "post_abort");

    // A few random operands against the model.
    for (int i = 0; i < 6; i++) begin
      run_op(W'($urandom), W'($urandom), 1'b0, 1'b0, $sformatf("rnd%0d", i));
    end

    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sub_serial.md
Name: sub_serial

Overview:
- Bit-serial subtractor. Computes `a - b` one bit per clock, LSB first, using a single full-subtractor cell and a borrow flop.
- Companion to the bit-serial adder in the same arithmetic datapath library. It is the inverse operation, used where area matters more than latency.
- Loads parallel operands on `en` and returns a parallel difference, a borrow flag and a done indication.

Parameters:
- `WIDTH`, 8, operand and result width in bits; legal range 2..32.
- `CW`, `$clog2(WIDTH)`, counter width; derived, must not be overridden.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  start request in IDLE; acknowledge/release in DONE.
- `a`  in  `WIDTH`  minuend, sampled on the start edge only.
- `b`  in  `WIDTH`  subtrahend, sampled on the start edge only.
- `out`  out  `WIDTH`  difference `a - b` modulo 2^`WIDTH`; valid while `done` = 1.
- `borrow_out`  out  1  1 when `a < b` unsigned; valid while `done` = 1.
- `busy`  out  1  1 while in SUB.
- `done`  out  1  1 while in DONE.

Behaviour:
- Reset is asynchronous on `rst` = 0. It forces:
  - `state` = IDLE
  - `a_reg`, `b_reg`, `out`, `count`, `borrow` = 0
  - `borrow_out` = 0, `busy` = 0, `done` = 0
- Reset asserted mid-operation aborts the subtraction immediately. No partial result is retained.
- States: IDLE, SUB, DONE. Encoding is a 2-bit localparam in the package.
- IDLE:
  - If `en` = 1 at the edge: `a_reg` <= `a`, `b_reg` <= `b`, `borrow` <= 0, `count` <= 0, `out` <= 0; go to SUB.
  - Otherwise stay in IDLE; all registers hold.
- SUB, on each edge:
  - `d` = `a_reg[0]` ^ `b_reg[0]` ^ `borrow`.
  - `out` <= {`d`, `out[WIDTH-1:1]`}.
  - `borrow` <= (~`a_reg[0]` & `b_reg[0]`) | (~(`a_reg[0]` ^ `b_reg[0]`) & `borrow`).
  - `a_reg` and `b_reg` logical-shift right by 1; `count` <= `count` + 1.
  - When `count` == `WIDTH`-1, go to DONE; otherwise stay in SUB.
  - `en` is ignored in SUB.
- Latency: start edge E0 is followed by `WIDTH` SUB edges. `done` rises after edge E0+`WIDTH`, i.e. it is visible in the cycle following that edge.
- `borrow_out` is combinationally equal to the `borrow` register. It is only meaningful in DONE.
- DONE:
  - `out` and `borrow` hold.
  - `en` = 1 goes to IDLE; outputs stay held.
  - A new operation needs `en` = 1 again once in IDLE, so back-to-back operations have a minimum spacing of `WIDTH`+2 cycles.
- `busy` = (`state` == SUB) and `done` = (`state` == DONE), both decoded from registered state.
- Unused state encoding (3) returns to IDLE on the next edge; data registers hold.
- All arithmetic is unsigned modulo 2^`WIDTH`. `a` == `b` gives `out` = 0, `borrow_out` = 0.

Optional Feature:
- Macro: `SUB_SERIAL_OVF_EN`.
- With the macro defined:
  - Extra output `ovf` (1 bit): two's-complement signed overflow.
  - `ovf` is registered on the final SUB edge as `borrow`-into-MSB XOR `borrow`-out-of-MSB.
  - It is cleared on reset and on start, and held in DONE.
- Without the macro: no `ovf` port and no extra logic. The port list is exactly as above.

Decomposition:
- Package `serial_arith_pkg` holds:
  - the state localparams IDLE = 0, SUB = 1, DONE = 2;
  - a shared full-subtractor bit function returning {`borrow_next`, `d`}.
- A sub-module is natural: `serial_fs_cell`, a combinational 1-bit full subtractor.
- The FSM, shifters and counter stay in `sub_serial`.

Test Plan:
- Reset then idle: hold `rst` = 0 for 2 cycles, release with `en` = 0 for 10 cycles → `out` = 0x00, `done` = 0, `busy` = 0 throughout.
- `WIDTH` = 8, `a` = 0x35, `b` = 0x12, `en` pulse → `busy` high for 8 cycles; `done` = 1 nine cycles after the start edge; `out` = 0x23, `borrow_out` = 0.
- `a` = 0x12, `b` = 0x35 → `out` = 0xDD, `borrow_out` = 1. Also `a` = 0x00, `b` = 0x01 → `out` = 0xFF, `borrow_out` = 1.
- Start with `a` = 0xAA, `b` = 0x55, then drive `en` = 1 and change `a`/`b` during SUB → no restart; result `out` = 0x55, `borrow_out` = 0. In DONE, `en` = 1 → IDLE with `out` held at 0x55.
- Assert `rst` = 0 at the 4th SUB cycle → same cycle: `out` = 0, `busy` = 0, `state` = IDLE. A new start then completes correctly.
- With `SUB_SERIAL_OVF_EN`:
  - `a` = 0x80, `b` = 0x01 → `out` = 0x7F, `ovf` = 1, `borrow_out` = 0.
  - `a` = 0x05, `b` = 0x03 → `ovf` = 0.
